coord_scan_ctrl: RTL and testbench
==================================

# coord_scan_ctrl

Search-window scan controller for the interpolation datapath. Walks the upper-left candidate block coordinate (X, Y) over a square, signed search window in raster order. For each candidate it loads the coordinate into the horizontal and vertical coordinate registers through a write-enable pulse, then holds a request to the interpolation datapath until that datapath acknowledges. It sits between the top-level control (START/ABORT) and the coordinate registers plus interpolation engine.

## Interface
Parameters:
- SR, 16, search range; coordinates span −SR..+SR inclusive, 1 ≤ SR ≤ 127
- STEP, 4, coordinate increment on both axes; (2·SR) mod STEP must be 0 (elaboration-time check)
- COORD_W, 8, signed coordinate width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_ASYNC  in  1  asynchronous, active-high reset
- START  in  1  begin a scan; sampled only in IDLE
- ABORT  in  1  terminate a scan; no DONE is produced
- ACK  in  1  datapath finished the current candidate; sampled only in REQ
- COORD_X  out  COORD_W  signed candidate X, driven to the coordinate register DATA_IN
- COORD_Y  out  COORD_W  signed candidate Y
- WRITE_EN  out  1  one-cycle load pulse to both coordinate registers
- REQ  out  1  candidate valid for the datapath
- LAST  out  1  high with REQ for the final candidate only
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse after the final ACK

## Operation
- All outputs are registered. Reset value is 0 for every output, and the state is IDLE. COORD_X/COORD_Y reset to 0, not −SR.
- FSM states: IDLE, LOAD, REQ, FIN.
- IDLE: if START is sampled, set X = Y = −SR and go to LOAD.
- LOAD, which always lasts one cycle: WRITE_EN = 1 with the current COORD_X/COORD_Y, then go to REQ.
- REQ: REQ = 1 and LAST = (X == SR && Y == SR).
  - If ACK is sampled and this is not the last candidate: advance the coordinate, then go to LOAD.
  - If ACK is sampled on the last candidate: go to FIN.
  - Without ACK: stay in REQ with the coordinate stable.
- FIN: DONE = 1 for one cycle, then go to IDLE. COORD_X/COORD_Y keep (SR, SR).
- Advance rule, compare-before-add so there is no overflow:
  - If X ≠ SR, then X += STEP.
  - Otherwise X = −SR and Y += STEP.
- Candidate count is (2·SR/STEP + 1)². With the defaults this is 81.
- ABORT in any non-IDLE state returns the FSM to IDLE on the next edge. REQ, WRITE_EN and LAST clear, DONE is not asserted, and COORD holds its last value. ABORT has priority over ACK.
- START outside IDLE is ignored. ACK outside REQ is ignored.
- When START and ABORT are both high in IDLE, ABORT wins and the FSM stays in IDLE.

## Timing
- If START is high at edge n, then LOAD with WRITE_EN runs in cycle n+1 and REQ is first high in cycle n+2.
- Coordinate registers capture at the end of the LOAD cycle. Their outputs are therefore valid in the first REQ cycle.
- ACK may be high in the same cycle that REQ rises; it is accepted.
- The minimum is 2 cycles per candidate (LOAD + REQ). With ACK tied high, the defaults give a first REQ at n+2, the final REQ at n+162, and DONE at n+163.
- Reset mid-scan: outputs go to 0 immediately (asynchronously). The next scan requires a fresh START after RST_ASYNC deasserts.

## Structure
- Shared package coord_scan_pkg holds:
  - the state enum (IDLE, LOAD, REQ, FIN)
  - the COORD_W default
  - a function that computes the candidate count from SR and STEP
- Sub-module coord_step_counter: one signed axis counter with load-to-min, step, an at-max flag and wrap. It is instantiated twice. The X instance's at-max flag gates the Y step.

## Test plan
- Defaults, START pulse, ACK tied high:
  - WRITE_EN coordinates in order (−16,−16), (−12,−16) … (16,−16), (−16,−12) … (16,16), 81 in total.
  - LAST asserts only on (16,16). DONE is at START+163 and is one cycle wide.
- ACK delayed 3 cycles per candidate:
  - REQ and COORD stay stable while waiting.
  - Exactly one WRITE_EN per candidate; the scan finishes with 81 ACKs.
- ABORT in REQ of the 10th candidate (−16,−12) while ACK is also high:
  - IDLE and BUSY = 0 on the next cycle, with no DONE.
  - A new START restarts at (−16,−16).
- Spurious stimulus: START pulsed during REQ, and ACK pulsed in IDLE and in LOAD.
  - Both are ignored; coordinate sequence and candidate count are unchanged.
- Assert RST_ASYNC mid-LOAD:
  - All outputs are 0 within the same cycle, without waiting for a clock edge.
  - The FSM stays in IDLE until START.
- SR=1, STEP=2:
  - Candidates (−1,−1), (1,−1), (−1,1), (1,1).
  - LAST on the 4th; DONE follows.

Source files
------------

// File: rtl/coord_scan_pkg.sv
// Shared types and helpers for the search-window scan controller.
// Holds the FSM encoding and the candidate-count helper.
package coord_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_FIN
  } state_t;

  localparam int COORD_W_DEF = 8;

  function automatic int cand_count(
    input int sr,
    input int step
  );
    int n;
    n = (2 * sr) / step + 1;
    return n * n;
  endfunction

endpackage

// File: rtl/coord_step_counter.sv
// One signed axis counter: load to -SR, step by STEP,
// wrap back to -SR when stepped at +SR.
module coord_step_counter
  import coord_scan_pkg::*;
#(
  parameter int SR   = 16,
  parameter int STEP = 4,
  parameter int W    = COORD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_min,
  input  logic                step_en,
  output logic signed [W-1:0] value,
  output logic                at_max
);

  localparam logic signed [W-1:0] MAXV  = W'(SR);
  localparam logic signed [W-1:0] MINV  = -MAXV;
  localparam logic signed [W-1:0] STEPV = W'(STEP);

  // compare before add, so +SR never overflows
  assign at_max = (value == MAXV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load_min) begin
      value <= MINV;
    end else if (step_en) begin
      value <= at_max ? MINV : value + STEPV;
    end
  end

endmodule

// File: rtl/coord_scan_ctrl.sv
// Raster scan of the signed search window, one load pulse
// and one held request per candidate block coordinate.
module coord_scan_ctrl
  import coord_scan_pkg::*;
#(
  parameter int SR      = 16,
  parameter int STEP    = 4,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                      CLK,
  input  logic                      RST_ASYNC,
  input  logic                      START,
  input  logic                      ABORT,
  input  logic                      ACK,
  output logic signed [COORD_W-1:0] COORD_X,
  output logic signed [COORD_W-1:0] COORD_Y,
  output logic                      WRITE_EN,
  output logic                      REQ,
  output logic                      LAST,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int NCAND = cand_count(SR, STEP);

  if (SR < 1 || SR > 127 || STEP < 1 ||
      ((2 * SR) % STEP) != 0 || NCAND < 4 ||
      SR >= (1 << (COORD_W - 1))) begin : g_bad_param
    $error("coord_scan_ctrl: illegal SR/STEP/COORD_W");
  end

  state_t state;
  state_t state_n;
  logic   load_min;
  logic   adv;
  logic   x_max;
  logic   y_max;
  logic   at_last;

  assign at_last = x_max & y_max;

  always_comb begin
    state_n  = state;
    load_min = 1'b0;
    adv      = 1'b0;
    if (ABORT) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            state_n  = ST_LOAD;
            load_min = 1'b1;
          end
        end
        ST_LOAD: state_n = ST_REQ;
        ST_REQ: begin
          if (ACK) begin
            if (at_last) begin
              state_n = ST_FIN;
            end else begin
              state_n = ST_LOAD;
              adv     = 1'b1;
            end
          end
        end
        ST_FIN:  state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // outputs are registered off the next state
  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state    <= ST_IDLE;
      WRITE_EN <= 1'b0;
      REQ      <= 1'b0;
      LAST     <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_n;
      WRITE_EN <= (state_n == ST_LOAD);
      REQ      <= (state_n == ST_REQ);
      LAST     <= (state_n == ST_REQ) && at_last;
      BUSY     <= (state_n != ST_IDLE);
      DONE     <= (state_n == ST_FIN);
    end
  end

  coord_step_counter #(
    .SR  (SR),
    .STEP(STEP),
    .W   (COORD_W)
  ) u_x (
    .clk     (CLK),
    .rst     (RST_ASYNC),
    .load_min(load_min),
    .step_en (adv),
    .value   (COORD_X),
    .at_max  (x_max)
  );

  // Y advances only on the X wrap
  coord_step_counter #(
    .SR  (SR),
    .STEP(STEP),
    .W   (COORD_W)
  ) u_y (
    .clk     (CLK),
    .rst     (RST_ASYNC),
    .load_min(load_min),
    .step_en (adv & x_max),
    .value   (COORD_Y),
    .at_max  (y_max)
  );

endmodule

// File: tb/tb_coord_scan_ctrl.sv
// Scoreboard bench for coord_scan_ctrl: default window
// plus a tiny SR=1/STEP=2 instance.
module tb_coord_scan_ctrl;

  localparam int SR   = 16;
  localparam int STEP = 4;
  localparam int W    = 8;

  typedef struct {
    int x;
    int y;
    bit last;
  } cand_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ack = 1'b0;
  logic signed [W-1:0] cx, cy;
  logic we, req, last, busy, done;

  logic s_start = 1'b0;
  logic s_abort = 1'b0;
  logic s_ack = 1'b1;
  logic signed [W-1:0] s_x, s_y;
  logic s_we, s_req, s_last, s_busy, s_done;

  coord_scan_ctrl #(.SR(SR), .STEP(STEP), .COORD_W(W)) u_dut (
    .CLK(clk), .RST_ASYNC(rst), .START(start),
    .ABORT(abort), .ACK(ack),
    .COORD_X(cx), .COORD_Y(cy), .WRITE_EN(we),
    .REQ(req), .LAST(last), .BUSY(busy), .DONE(done)
  );

  coord_scan_ctrl #(.SR(1), .STEP(2), .COORD_W(W)) u_small (
    .CLK(clk), .RST_ASYNC(rst), .START(s_start),
    .ABORT(s_abort), .ACK(s_ack),
    .COORD_X(s_x), .COORD_Y(s_y), .WRITE_EN(s_we),
    .REQ(s_req), .LAST(s_last), .BUSY(s_busy), .DONE(s_done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // reference model: raster order straight from the window rules
  cand_t q[$];
  cand_t q2[$];

  task automatic push_main();
    for (int y = -SR; y <= SR; y += STEP)
      for (int x = -SR; x <= SR; x += STEP)
        q.push_back('{x, y, (x == SR && y == SR)});
  endtask

  task automatic push_small();
    for (int y = -1; y <= 1; y += 2)
      for (int x = -1; x <= 1; x += 2)
        q2.push_back('{x, y, (x == 1 && y == 1)});
  endtask

  // main monitor
  cand_t cur;
  bit have_cur = 0;
  bit prev_done = 0;
  bit chk_lat = 0;
  bit first_req_seen = 0;
  int start_cyc = 0;
  int wes = 0;
  int dones = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        if (q.size() == 0) begin
          chk("extra_write_en", 1, 0);
        end else begin
          cur = q.pop_front();
          have_cur = 1;
          wes++;
          chk("we_x", int'(cx), cur.x);
          chk("we_y", int'(cy), cur.y);
        end
      end
      if (req) begin
        if (!have_cur) begin
          chk("req_without_load", 1, 0);
        end else begin
          chk("req_x", int'(cx), cur.x);
          chk("req_y", int'(cy), cur.y);
          chk("last", int'(last), int'(cur.last));
        end
        if (chk_lat && !first_req_seen) begin
          first_req_seen = 1;
          chk("first_req_latency", cyc - start_cyc, 2);
        end
      end else if (last) begin
        chk("last_without_req", 1, 0);
      end
      if (done) begin
        dones++;
        chk("done_queue_empty", q.size(), 0);
        chk("done_after_last", int'(have_cur && cur.last), 1);
        if (chk_lat)
          chk("done_latency", cyc - start_cyc, 163);
        if (prev_done)
          chk("done_width", 1, 0);
      end
      prev_done = done;
    end
  end

  // small-instance monitor
  cand_t c2;
  int s_wes = 0;
  int s_dones = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (s_we) begin
        if (q2.size() == 0) begin
          chk("s_extra_write_en", 1, 0);
        end else begin
          c2 = q2.pop_front();
          s_wes++;
          chk("s_we_x", int'(s_x), c2.x);
          chk("s_we_y", int'(s_y), c2.y);
        end
      end
      if (s_req)
        chk("s_last", int'(s_last), int'(c2.last));
      if (s_done) begin
        s_dones++;
        chk("s_done_after_last", int'(c2.last), 1);
      end
    end
  end

  // ACK driver: 0 tied high, 1 three-cycle delay,
  // 2 random at any time, 3 off
  int ack_mode = 3;
  int wait_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      case (ack_mode)
        0: ack = 1'b1;
        1: begin
          if (req && !ack) begin
            if (wait_cnt == 3) begin
              ack = 1'b1;
              wait_cnt = 0;
            end else begin
              wait_cnt++;
            end
          end else begin
            ack = 1'b0;
          end
        end
        2: ack = ($urandom % 3 == 0);
        default: ack = 1'b0;
      endcase
    end
  end

  task automatic run_scan(input int mode, input bit spurious,
                          input bit lat);
    int n;
    int exp_n;
    ack_mode = mode;
    push_main();
    exp_n = q.size();
    dones = 0;
    wes = 0;
    first_req_seen = 0;
    @(negedge clk);
    chk_lat = lat;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dones == 0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (spurious)
        start = busy && ($urandom % 5 == 0);
    end
    start = 1'b0;
    chk("scan_finished", dones, 1);
    chk("candidate_count", wes, exp_n);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("single_done", dones, 1);
    chk_lat = 0;
    ack_mode = 3;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req", int'(req), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_x", int'(cx), 0);
    chk("reset_y", int'(cy), 0);
    chk("reset_outs", int'({we, req, last, busy, done}), 0);

    // ACK tied high, exact latency
    run_scan(0, 1'b0, 1'b1);
    // ACK delayed per candidate
    run_scan(1, 1'b0, 1'b0);
    // spurious START in scan, random ACK incl. IDLE/LOAD
    run_scan(2, 1'b1, 1'b0);

    // ABORT on the 10th candidate with ACK high
    ack_mode = 0;
    push_main();
    wes = 0;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(wes == 10 && req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached", int'(n < 500), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outs", int'({we, req, last, done}), 0);
    chk("abort_hold_x", int'(cx), -16);
    chk("abort_hold_y", int'(cy), -12);
    q.delete();
    have_cur = 0;
    ack_mode = 3;
    repeat (3) @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    chk("abort_no_done", dones, 0);
    run_scan(0, 1'b0, 1'b0);

    // async reset in the middle of LOAD
    ack_mode = 1;
    push_main();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!we && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("load_reached", int'(we), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_outs", int'({we, req, last, busy, done}), 0);
    chk("async_rst_x", int'(cx), 0);
    chk("async_rst_y", int'(cy), 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    have_cur = 0;
    ack_mode = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    chk("post_rst_we", int'(we), 0);
    run_scan(0, 1'b0, 1'b0);

    // SR=1, STEP=2 instance
    push_small();
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_dones == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("s_done", s_dones, 1);
    chk("s_count", s_wes, 4);
    chk("s_busy_after", int'(s_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
